// File: rtl/csi_rx_pkg.sv
// Shared types for the CSI-2 receiver D-PHY lane control: lane FSM states and LP line encodings.
package csi_rx_pkg;

  typedef enum logic [2:0] {
    ST_STOP    = 3'd0,
    ST_HS_RQST = 3'd1,
    ST_BRIDGE  = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_SYNC    = 3'd4,
    ST_HS      = 3'd5,
    ST_ERR     = 3'd6
  } lane_state_e;

  // LP line state as {p, n}
  localparam logic [1:0] LP_11 = 2'b11;
  localparam logic [1:0] LP_01 = 2'b01;
  localparam logic [1:0] LP_00 = 2'b00;
  localparam logic [1:0] LP_10 = 2'b10;

  localparam int CNT_W = 16;

endpackage

// File: rtl/dphy_lp_sync.sv
// Two-flop synchroniser for the LP comparator pair, decoded to lp = {p, n}; 2 cycles latency.
// No flow control; resets to LP-11 (idle line).
module dphy_lp_sync
  import csi_rx_pkg::*;
(
  input  logic       dphy_clk,
  input  logic       areset,
  input  logic       lp_p,
  input  logic       lp_n,
  output logic [1:0] lp
);

  logic [1:0] meta_q;
  logic [1:0] sync_q;

  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      meta_q <= LP_11;
      sync_q <= LP_11;
    end else begin
      meta_q <= {lp_p, lp_n};
      sync_q <= meta_q;
    end
  end

  assign lp = sync_q;

endmodule

// File: rtl/dphy_rx_lane_ctrl.sv
// D-PHY data-lane LP->HS->LP burst sequencer; outputs are registered state decodes (1 cycle behind state).
// No backpressure: SoT/packet_done pulses are sampled every cycle, errors are single-cycle pulses.
module dphy_rx_lane_ctrl
  import csi_rx_pkg::*;
#(
  parameter int LANES         = 2,
  parameter int SETTLE_CYCLES = 6,
  parameter int SYNC_TIMEOUT  = 64,
  parameter int MAX_HS_CYCLES = 32768
) (
  input  logic             dphy_clk,
  input  logic             areset,
  input  logic             lp_p,
  input  logic             lp_n,
  input  logic [LANES-1:0] sync_found,
  input  logic             packet_done,
  output logic             hs_enable,
  output logic             aligner_reset,
  output logic             wait_for_sync,
  output logic             in_hs,
  output logic             err_sot,
  output logic             err_timeout,
  output logic [7:0]       err_count,
  output logic [2:0]       state_dbg
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(SYNC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HS_LAST     = CNT_W'(MAX_HS_CYCLES - 1);
  localparam logic [LANES-1:0] ALL_LANES   = '1;

  lane_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LANES-1:0] seen_q, seen_d;
  logic             lp11_q;
  logic             sot_d, tmo_d;
  logic [1:0]       lp;

  dphy_lp_sync u_lp_sync (
    .dphy_clk (dphy_clk),
    .areset   (areset),
    .lp_p     (lp_p),
    .lp_n     (lp_n),
    .lp       (lp)
  );

  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      state_q <= ST_STOP;
      cnt_q   <= '0;
      seen_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    sot_d   = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      ST_STOP: begin
        cnt_d = '0;
        if (lp == LP_01) begin
          state_d = ST_HS_RQST;
        end else if (lp == LP_10) begin
          state_d = ST_ERR;
          sot_d   = 1'b1;
        end
      end
      ST_HS_RQST: begin
        if (lp == LP_00) begin
          state_d = ST_BRIDGE;
        end else if (lp == LP_11) begin
          state_d = ST_STOP;
        end else if (lp == LP_10) begin
          state_d = ST_ERR;
          sot_d   = 1'b1;
        end
      end
      ST_BRIDGE: begin
        cnt_d   = SETTLE_LOAD;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (lp == LP_11) begin
          state_d = ST_STOP;
        end else if (cnt_q == '0) begin
          state_d = ST_SYNC;
          seen_d  = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SYNC: begin
        // Early lanes are remembered so staggered SoT still completes the set.
        seen_d = seen_q | sync_found;
        cnt_d  = cnt_q + 1'b1;
        if (lp == LP_11) begin
          state_d = ST_STOP;
          sot_d   = 1'b1;
        end else if ((seen_q | sync_found) == ALL_LANES) begin
          state_d = ST_HS;
          cnt_d   = '0;
        end else if (cnt_q == SYNC_LAST) begin
          state_d = ST_ERR;
          sot_d   = 1'b1;
        end
      end
      ST_HS: begin
        cnt_d = cnt_q + 1'b1;
        if (packet_done || lp == LP_11) begin
          state_d = ST_STOP;
        end else if (cnt_q == HS_LAST) begin
          state_d = ST_ERR;
          tmo_d   = 1'b1;
        end
      end
      ST_ERR: begin
        if (lp == LP_11 && lp11_q) state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      lp11_q        <= 1'b0;
      hs_enable     <= 1'b0;
      aligner_reset <= 1'b1;
      wait_for_sync <= 1'b0;
      in_hs         <= 1'b0;
      err_sot       <= 1'b0;
      err_timeout   <= 1'b0;
      err_count     <= '0;
    end else begin
      lp11_q        <= (state_q == ST_ERR) && (lp == LP_11);
      hs_enable     <= (state_q == ST_SYNC) || (state_q == ST_HS);
      aligner_reset <= !((state_q == ST_SYNC) || (state_q == ST_HS));
      wait_for_sync <= (state_q == ST_SYNC);
      in_hs         <= (state_q == ST_HS);
      err_sot       <= sot_d;
      err_timeout   <= tmo_d;
      if ((sot_d || tmo_d) && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_dphy_rx_lane_ctrl.sv
// Directed bench for dphy_rx_lane_ctrl with a cycle-level reference model checked every cycle.
module tb_dphy_rx_lane_ctrl;

  localparam int SETTLE = 6;
  localparam int TMO    = 64;
  localparam int MAXHS  = 100;

  logic       dphy_clk = 1'b0;
  logic       areset = 1'b1;
  logic       lp_p = 1'b1, lp_n = 1'b1;
  logic [1:0] sync_found = 2'b00;
  logic       packet_done = 1'b0;
  logic       hs_enable, aligner_reset, wait_for_sync, in_hs, err_sot, err_timeout;
  logic [7:0] err_count;
  logic [2:0] state_dbg;

  int tests = 0;
  int fails = 0;

  always #5 dphy_clk = ~dphy_clk;

  dphy_rx_lane_ctrl #(
    .LANES(2), .SETTLE_CYCLES(SETTLE), .SYNC_TIMEOUT(TMO), .MAX_HS_CYCLES(MAXHS)
  ) dut (
    .dphy_clk(dphy_clk), .areset(areset), .lp_p(lp_p), .lp_n(lp_n),
    .sync_found(sync_found), .packet_done(packet_done),
    .hs_enable(hs_enable), .aligner_reset(aligner_reset), .wait_for_sync(wait_for_sync),
    .in_hs(in_hs), .err_sot(err_sot), .err_timeout(err_timeout),
    .err_count(err_count), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge dphy_clk);
  endtask

  task automatic set_lp(input logic [1:0] v);
    lp_p = v[1];
    lp_n = v[0];
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (state_dbg !== s && n < budget) begin
      cyc(1);
      n++;
    end
    check(name, 32'(state_dbg), 32'(s));
  endtask

  // Reference model: phase plus time-in-phase, LP seen two cycles late.
  int         m_state = 0, m_t = 0, m_run11 = 0, m_cnt = 0, m_lp = 3, m_nxt = 0;
  bit         m_es, m_et;
  bit         m_hs_en = 0, m_alrst = 1, m_wfs = 0, m_inhs = 0, m_esot = 0, m_eto = 0;
  logic [1:0] m_seen = 2'b00, pipe0 = 2'b11, pipe1 = 2'b11;

  always @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      m_state = 0; m_t = 0; m_run11 = 0; m_cnt = 0; m_seen = 2'b00;
      pipe0 = 2'b11; pipe1 = 2'b11;
      m_hs_en = 0; m_alrst = 1; m_wfs = 0; m_inhs = 0; m_esot = 0; m_eto = 0;
    end else begin
      m_lp = int'(pipe1);
      pipe1 = pipe0;
      pipe0 = {lp_p, lp_n};
      m_nxt = m_state; m_es = 0; m_et = 0;
      case (m_state)
        0: if (m_lp == 1) m_nxt = 1;
           else if (m_lp == 2) begin m_nxt = 6; m_es = 1; end
        1: if (m_lp == 0) m_nxt = 2;
           else if (m_lp == 3) m_nxt = 0;
           else if (m_lp == 2) begin m_nxt = 6; m_es = 1; end
        2: m_nxt = 3;
        3: if (m_lp == 3) m_nxt = 0;
           else if (m_t == SETTLE - 1) m_nxt = 4;
        4: if (m_lp == 3) begin m_nxt = 0; m_es = 1; end
           else if ((m_seen | sync_found) == 2'b11) m_nxt = 5;
           else if (m_t == TMO - 1) begin m_nxt = 6; m_es = 1; end
        5: if (packet_done || m_lp == 3) m_nxt = 0;
           else if (m_t == MAXHS - 1) begin m_nxt = 6; m_et = 1; end
        6: begin
          m_run11 = (m_lp == 3) ? m_run11 + 1 : 0;
          if (m_run11 >= 2) m_nxt = 0;
        end
        default: m_nxt = 0;
      endcase
      if (m_nxt == 4 && m_state != 4) m_seen = 2'b00;
      else if (m_state == 4) m_seen = m_seen | sync_found;
      if (m_nxt == 6 && m_state != 6) m_run11 = 0;
      m_hs_en = (m_state == 4 || m_state == 5);
      m_alrst = !m_hs_en;
      m_wfs   = (m_state == 4);
      m_inhs  = (m_state == 5);
      m_esot  = m_es;
      m_eto   = m_et;
      if ((m_es || m_et) && m_cnt < 255) m_cnt++;
      m_t = (m_nxt != m_state) ? 0 : m_t + 1;
      m_state = m_nxt;
    end
  end

  always @(negedge dphy_clk) begin
    if (!areset)
      check("cycle_outputs",
            {15'd0, hs_enable, aligner_reset, wait_for_sync, in_hs, err_sot, err_timeout, err_count, state_dbg},
            {15'd0, m_hs_en, m_alrst, m_wfs, m_inhs, m_esot, m_eto, 8'(m_cnt), 3'(m_state)});
  end

  task automatic enter_hs(input string name);
    set_lp(2'b01); cyc(4); set_lp(2'b00);
    wait_state(3'd4, 40, {name, "_sync"});
    sync_found = 2'b11; cyc(1); sync_found = 2'b00;
    check({name, "_hs"}, 32'(state_dbg), 32'd5);
  endtask

  initial begin
    int n;
    int k;
    cyc(3);
    check("rst_outs", 32'({hs_enable, aligner_reset, wait_for_sync, in_hs, err_sot, err_timeout}), 32'b010000);
    check("rst_count", 32'(err_count), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    areset = 1'b0;
    cyc(3);

    // Nominal burst
    set_lp(2'b11); cyc(10);
    set_lp(2'b01); cyc(10);
    check("nom_rqst", 32'(state_dbg), 32'd1);
    set_lp(2'b00);
    wait_state(3'd2, 10, "nom_bridge");
    wait_state(3'd3, 5, "nom_settle");
    n = 0;
    while (state_dbg == 3'd3 && n < 50) begin cyc(1); n++; end
    check("nom_settle_len", n, 32'd6);
    check("nom_sync", 32'(state_dbg), 32'd4);
    check("nom_hs_en_entry", 32'({hs_enable, aligner_reset}), 32'b01);
    cyc(1);
    check("nom_hs_en_rise", 32'({hs_enable, aligner_reset}), 32'b10);
    cyc(2);
    sync_found = 2'b11; cyc(1); sync_found = 2'b00;
    check("nom_hs", 32'(state_dbg), 32'd5);
    cyc(60);
    packet_done = 1'b1; cyc(1); packet_done = 1'b0;
    check("nom_stop", 32'(state_dbg), 32'd0);
    check("nom_hs_en_tail", 32'(hs_enable), 32'd1);
    cyc(1);
    check("nom_hs_en_off", 32'(hs_enable), 32'd0);
    check("nom_err_count", 32'(err_count), 32'd0);
    set_lp(2'b11); cyc(4);

    // Staggered lanes
    set_lp(2'b01); cyc(4); set_lp(2'b00);
    wait_state(3'd4, 40, "stag_sync");
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 9)  check("stag_still_sync", 32'(state_dbg), 32'd4);
      if (c == 10) check("stag_hs_entry", 32'(state_dbg), 32'd5);
      sync_found = (c == 5) ? 2'b01 : (c == 9) ? 2'b10 : 2'b00;
      cyc(1);
      n += int'(wait_for_sync);
    end
    sync_found = 2'b00;
    check("stag_wfs_len", n, 32'd10);
    set_lp(2'b11);
    wait_state(3'd0, 20, "stag_stop");

    // SYNC timeout
    set_lp(2'b01); cyc(4); set_lp(2'b00);
    wait_state(3'd4, 40, "to_sync");
    n = 0;
    while (state_dbg == 3'd4 && n < 200) begin
      sync_found = (n == 2) ? 2'b01 : 2'b00;
      cyc(1);
      n++;
    end
    sync_found = 2'b00;
    check("to_len", n, 32'd64);
    check("to_state", 32'(state_dbg), 32'd6);
    check("to_pulse", 32'(err_sot), 32'd1);
    check("to_count", 32'(err_count), 32'd1);
    cyc(1);
    check("to_pulse_end", 32'(err_sot), 32'd0);
    set_lp(2'b11); cyc(3);
    check("to_err_hold", 32'(state_dbg), 32'd6);
    cyc(1);
    check("to_err_exit", 32'(state_dbg), 32'd0);

    // Invalid LP from STOP, then from HS_RQST
    set_lp(2'b10);
    wait_state(3'd6, 10, "inv_stop_err");
    check("inv_stop_pulse", 32'(err_sot), 32'd1);
    check("inv_stop_count", 32'(err_count), 32'd2);
    set_lp(2'b11); cyc(4);
    check("inv_stop_back", 32'(state_dbg), 32'd0);
    set_lp(2'b01);
    wait_state(3'd1, 10, "inv_rqst_rqst");
    set_lp(2'b10);
    wait_state(3'd6, 10, "inv_rqst_err");
    check("inv_rqst_pulse", 32'(err_sot), 32'd1);
    check("inv_rqst_count", 32'(err_count), 32'd3);
    set_lp(2'b11); cyc(4);
    check("inv_rqst_back", 32'(state_dbg), 32'd0);

    // Aborted request
    set_lp(2'b01);
    wait_state(3'd1, 10, "abort_rqst");
    set_lp(2'b11);
    wait_state(3'd0, 10, "abort_stop");
    cyc(3);
    check("abort_count", 32'(err_count), 32'd3);

    // HS overrun
    enter_hs("ovr");
    k = 0;
    while (!err_timeout && k < 300) begin cyc(1); k++; end
    check("ovr_len", k, 32'd100);
    check("ovr_state", 32'(state_dbg), 32'd6);
    check("ovr_count", 32'(err_count), 32'd4);
    set_lp(2'b11); cyc(4);
    check("ovr_back", 32'(state_dbg), 32'd0);

    // packet_done on the last allowed HS cycle
    enter_hs("pd99");
    cyc(99);
    check("pd99_still_hs", 32'(state_dbg), 32'd5);
    packet_done = 1'b1; cyc(1); packet_done = 1'b0;
    check("pd99_stop", 32'(state_dbg), 32'd0);
    check("pd99_no_tmo", 32'(err_timeout), 32'd0);
    check("pd99_count", 32'(err_count), 32'd4);
    set_lp(2'b11); cyc(3);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      set_lp(2'b10); cyc(1);
      set_lp(2'b11); cyc(3);
    end
    cyc(4);
    check("sat_count", 32'(err_count), 32'd255);
    check("sat_state", 32'(state_dbg), 32'd0);

    // Asynchronous reset during HS
    enter_hs("rst");
    cyc(5);
    areset = 1'b1;
    #1;
    check("arst_outs", 32'({hs_enable, aligner_reset, wait_for_sync, in_hs, err_sot, err_timeout}), 32'b010000);
    check("arst_count", 32'(err_count), 32'd0);
    check("arst_state", 32'(state_dbg), 32'd0);
    cyc(2);
    areset = 1'b0;
    cyc(5);
    check("arst_after", 32'(state_dbg), 32'd0);
    set_lp(2'b11); cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
